// File: rtl/fp_op_arbiter_if.sv
// Bundle of requester-side and FP-unit-side signals for fp_op_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface fp_op_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [32*N_REQ-1:0] i_REQ_A;
    logic [32*N_REQ-1:0] i_REQ_B;
    logic [N_REQ-1:0]    i_REQ_STB;
    logic [N_REQ-1:0]    o_REQ_ACK;
    logic [31:0]         o_RSP_Z;
    logic [N_REQ-1:0]    o_RSP_STB;
    logic [N_REQ-1:0]    i_RSP_ACK;
    logic [31:0]         o_FP_A;
    logic [31:0]         o_FP_B;
    logic                o_FP_AB_STB;
    logic                i_FP_AB_ACK;
    logic [31:0]         i_FP_Z;
    logic                i_FP_Z_STB;
    logic                o_FP_Z_ACK;
    logic [1:0]          o_GRANT;
    logic                o_BUSY;
    logic                o_ERR;

    modport master (
        input  i_REQ_A, i_REQ_B, i_REQ_STB, i_RSP_ACK, i_FP_AB_ACK, i_FP_Z, i_FP_Z_STB,
        output o_REQ_ACK, o_RSP_Z, o_RSP_STB, o_FP_A, o_FP_B, o_FP_AB_STB, o_FP_Z_ACK,
               o_GRANT, o_BUSY, o_ERR
    );

    modport slave (
        output i_REQ_A, i_REQ_B, i_REQ_STB, i_RSP_ACK, i_FP_AB_ACK, i_FP_Z, i_FP_Z_STB,
        input  o_REQ_ACK, o_RSP_Z, o_RSP_STB, o_FP_A, o_FP_B, o_FP_AB_STB, o_FP_Z_ACK,
               o_GRANT, o_BUSY, o_ERR
    );
endinterface

// File: rtl/fp_op_arbiter.sv
// Round-robin arbiter sharing one floating-point unit among N_REQ requesters,
// one operation in flight, with a WAIT_Z timeout that returns qNaN and sets a sticky error.
module fp_op_arbiter #(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input logic             i_CLK,
    input logic             i_RSTN,
    fp_op_arbiter_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_Z, ST_RETURN} state_t;

    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [31:0]      QNAN     = 32'h7fc00000;
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

    state_t           state_q;
    logic [1:0]       grant_q;
    logic [1:0]       last_grant_q;
    logic [N_REQ-1:0] req_ack_q;
    logic [N_REQ-1:0] rsp_stb_q;
    logic [31:0]      rsp_z_q;
    logic [31:0]      fp_a_q;
    logic [31:0]      fp_b_q;
    logic             fp_ab_stb_q;
    logic             fp_z_ack_q;
    logic             busy_q;
    logic             err_q;
    logic [7:0]       tmo_q;

    logic             pick_vld_d;
    logic [1:0]       grant_d;
    logic [31:0]      a_sel_d;
    logic [31:0]      b_sel_d;
    logic [N_REQ-1:0] stb_rot_d;
    int               cand_d;

    // Search starts one past the last completed grant, so a continuously
    // requesting client waits behind every other active requester.
    always_comb begin
        pick_vld_d = 1'b0;
        grant_d    = '0;
        cand_d     = 0;
        stb_rot_d  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_d    = (int'(last_grant_q) + 1 + i) % N_REQ;
            stb_rot_d = bus.i_REQ_STB >> cand_d;
            if (!pick_vld_d && stb_rot_d[0]) begin
                pick_vld_d = 1'b1;
                grant_d    = 2'(cand_d);
            end
        end
        a_sel_d = 32'(bus.i_REQ_A >> (32 * int'(grant_d)));
        b_sel_d = 32'(bus.i_REQ_B >> (32 * int'(grant_d)));
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= 2'(N_REQ - 1);
            req_ack_q    <= '0;
            rsp_stb_q    <= '0;
            rsp_z_q      <= '0;
            fp_a_q       <= '0;
            fp_b_q       <= '0;
            fp_ab_stb_q  <= 1'b0;
            fp_z_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            req_ack_q  <= '0;
            fp_z_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_d) begin
                        grant_q     <= grant_d;
                        req_ack_q   <= ONE << grant_d;
                        fp_a_q      <= a_sel_d;
                        fp_b_q      <= b_sel_d;
                        fp_ab_stb_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (fp_ab_stb_q && bus.i_FP_AB_ACK) begin
                        fp_ab_stb_q <= 1'b0;
                        tmo_q       <= '0;
                        state_q     <= ST_WAIT_Z;
                    end
                end
                ST_WAIT_Z: begin
                    if (bus.i_FP_Z_STB) begin
                        rsp_z_q    <= bus.i_FP_Z;
                        fp_z_ack_q <= 1'b1;
                        rsp_stb_q  <= ONE << grant_q;
                        state_q    <= ST_RETURN;
                    end else if (tmo_q >= TMO_LAST) begin
                        err_q     <= 1'b1;
                        rsp_z_q   <= QNAN;
                        rsp_stb_q <= ONE << grant_q;
                        state_q   <= ST_RETURN;
                    end else if (tmo_q != 8'hff) begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                ST_RETURN: begin
                    // rsp_stb_q is one-hot on the grant, so this masks off other acks
                    if ((bus.i_RSP_ACK & rsp_stb_q) != '0) begin
                        rsp_stb_q    <= '0;
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_REQ_ACK   = req_ack_q;
    assign bus.o_RSP_Z     = rsp_z_q;
    assign bus.o_RSP_STB   = rsp_stb_q;
    assign bus.o_FP_A      = fp_a_q;
    assign bus.o_FP_B      = fp_b_q;
    assign bus.o_FP_AB_STB = fp_ab_stb_q;
    assign bus.o_FP_Z_ACK  = fp_z_ack_q;
    assign bus.o_GRANT     = grant_q;
    assign bus.o_BUSY      = busy_q;
    assign bus.o_ERR       = err_q;
endmodule

// File: doc/fp_op_arbiter.md
FP_OP_ARBITER -- requirements
Module: fp_op_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters; widths below scale with it, and the arbiter SHALL be verified at 3.
REQ-002 Parameter TIMEOUT_CYC, default 255, maximum WAIT_Z cycles before abort.
REQ-003 i_CLK  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 i_RSTN  in  1  asynchronous, active-low reset.
REQ-005 i_REQ_A, i_REQ_B  in  32*N_REQ each  per-requester float operands; slice k = [32k+31:32k].
REQ-006 i_REQ_STB  in  N_REQ  per-requester operands valid, held until the matching o_REQ_ACK.
REQ-007 o_REQ_ACK  out  N_REQ  one-cycle pulse: operands of requester k captured.
REQ-008 o_RSP_Z  out  32  result of the granted operation.
REQ-009 o_RSP_STB  out  N_REQ  one-hot result valid, held until the matching i_RSP_ACK.
REQ-010 i_RSP_ACK  in  N_REQ  requester k has taken o_RSP_Z.
REQ-011 o_FP_A, o_FP_B  out  32 each  operands to the shared float_adder/float_multiplier.
REQ-012 o_FP_AB_STB  out  1  operands valid to the FP unit; i_FP_AB_ACK  in  1  FP unit ready for operands.
REQ-013 i_FP_Z  in  32  FP result; i_FP_Z_STB  in  1  result valid; o_FP_Z_ACK  out  1  result taken.
REQ-014 o_GRANT  out  2  index of the current or last granted requester.
REQ-015 o_BUSY  out  1  high in every state except ST_IDLE.
REQ-016 o_ERR  out  1  sticky flag: timeout occurred.

Function
REQ-017 FSM states: ST_IDLE, ST_ISSUE, ST_WAIT_Z, ST_RETURN; exactly one operation in flight.
REQ-018 ST_IDLE:
- If any i_REQ_STB is high, grant the first requester in round-robin order, starting at (last_grant+1) mod N_REQ.
- Capture its operands into o_FP_A/o_FP_B, pulse its o_REQ_ACK for 1 cycle, set o_GRANT, go to ST_ISSUE.
REQ-019 ST_ISSUE: hold o_FP_AB_STB=1 with stable operands; in the cycle o_FP_AB_STB & i_FP_AB_ACK, drop o_FP_AB_STB next edge, clear the timeout counter, go to ST_WAIT_Z.
REQ-020 ST_WAIT_Z:
- On i_FP_Z_STB, register i_FP_Z into o_RSP_Z, pulse o_FP_Z_ACK for exactly 1 cycle, assert o_RSP_STB[grant], go to ST_RETURN.
- Otherwise increment the timeout counter (8-bit, saturating).
REQ-021 Timeout: if the counter reaches TIMEOUT_CYC in ST_WAIT_Z, set o_ERR, assert o_RSP_STB[grant] with o_RSP_Z=32'h7fc00000 (qNaN), go to ST_RETURN.
REQ-022 ST_RETURN: hold o_RSP_STB[grant] and o_RSP_Z until i_RSP_ACK[grant]=1; then clear o_RSP_STB, update last_grant, go to ST_IDLE.
REQ-023 i_RSP_ACK bits of non-granted requesters, and i_RSP_ACK outside ST_RETURN, SHALL be ignored.
REQ-024 Minimum per-operation overhead is 1 cycle in ST_IDLE; a requester whose STB is held continuously SHALL be granted again at most once every N_REQ grants when others are requesting.
REQ-025 Simultaneous requests SHALL be resolved by the REQ-018 order; a single requester alone SHALL be granted back-to-back.
REQ-026 i_REQ_STB changes during ST_ISSUE, ST_WAIT_Z or ST_RETURN SHALL NOT affect the operation in flight.
REQ-027 i_FP_Z_STB outside ST_WAIT_Z SHALL be ignored, and no o_FP_Z_ACK is generated for it.
REQ-028 Only o_ERR is sticky; it is cleared by reset only.

Reset
REQ-029 While i_RSTN=0, all state SHALL clear asynchronously:
- o_REQ_ACK, o_RSP_STB, o_FP_AB_STB, o_FP_Z_ACK, o_BUSY, o_ERR = 0
- o_RSP_Z, o_FP_A, o_FP_B = 0, o_GRANT = 0
- state = ST_IDLE, last_grant = N_REQ-1, timeout counter = 0
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no response; the first grant after release SHALL go to requester 0 if it is requesting.

Verification
REQ-031 Req0 A=3f800000 B=40000000 with an adder model of 4-cycle latency -> one o_REQ_ACK[0] pulse, o_RSP_Z=40400000, o_RSP_STB[0] held until i_RSP_ACK[0].
REQ-032 All three STB high continuously, immediate i_RSP_ACK -> grant sequence 0,1,2,0,1,2; each o_REQ_ACK exactly once per grant.
REQ-033 i_FP_AB_ACK held low for 10 cycles -> o_FP_AB_STB stays high with stable operands; ST_WAIT_Z is entered only after the handshake.
REQ-034 FP unit never raises i_FP_Z_STB -> after 255 WAIT_Z cycles o_ERR=1 and o_RSP_Z=7fc00000 to the granted requester; o_ERR stays 1 afterwards.
REQ-035 i_RSP_ACK delayed 5 cycles, and i_RSP_ACK[2] pulsed while grant=1 -> o_RSP_STB[1] held the full 5 cycles; the wrong-requester ack is ignored.
REQ-036 i_RSTN pulsed low during ST_WAIT_Z -> all outputs 0 immediately, o_ERR=0, next grant goes to requester 0.
